// File: rtl/dice_roll_sched.sv
// Round-robin roll scheduler sharing one dice generator among NUM_PLAYERS requesters.
// Define DICE_SCORE_EN to add saturating per-player score accumulators on the score port.
`timescale 1ns/1ps
module dice_roll_sched #(
   parameter int unsigned NUM_PLAYERS = 4,
   parameter int unsigned ROLL_CYCLES = 16,
   parameter int unsigned SHOW_CYCLES = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_PLAYERS-1:0]         req,
   input  logic [2:0]                     dice_val,
   output logic                           dice_en,
   output logic [NUM_PLAYERS-1:0]         grant,
   output logic [2:0]                     face,
   output logic [$clog2(NUM_PLAYERS)-1:0] face_player,
   output logic                           done,
`ifdef DICE_SCORE_EN
   output logic [NUM_PLAYERS*8-1:0]       score,
`endif
   output logic                           busy
);

   localparam int unsigned PW     = $clog2(NUM_PLAYERS);
   localparam int unsigned CPW    = PW + 1;
   localparam int unsigned MaxCyc = (ROLL_CYCLES > SHOW_CYCLES) ? ROLL_CYCLES : SHOW_CYCLES;
   localparam int unsigned CW     = $clog2(MaxCyc + 1);

   typedef enum logic [1:0] {StIdle, StRoll, StSettle, StShow} state_e;

   state_e                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [PW-1:0]          last_q, last_d;
   logic [PW-1:0]          winner_q, winner_d;
   logic                   dice_en_q, dice_en_d;
   logic [NUM_PLAYERS-1:0] grant_q, grant_d;
   logic [2:0]             face_q, face_d;
   logic [PW-1:0]          face_player_q, face_player_d;
   logic                   done_q, done_d;
   logic                   busy_q, busy_d;

   logic                   any_req;
   logic [PW-1:0]          pick;
   logic [CPW-1:0]         cand;
   logic                   face_ok;

   assign face_ok = (dice_val != 3'd0) && (dice_val != 3'd7);

   // Scan upward from the player after the last winner, wrapping modulo NUM_PLAYERS.
   always_comb begin
      any_req = 1'b0;
      pick    = '0;
      cand    = '0;
      for (int i = 1; i <= int'(NUM_PLAYERS); i++) begin
         cand = {1'b0, last_q} + CPW'(i);
         if (cand >= CPW'(NUM_PLAYERS)) begin
            cand = cand - CPW'(NUM_PLAYERS);
         end
         if (!any_req && req[cand[PW-1:0]]) begin
            any_req = 1'b1;
            pick    = cand[PW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         last_q        <= PW'(NUM_PLAYERS - 1);
         winner_q      <= '0;
         dice_en_q     <= 1'b0;
         grant_q       <= '0;
         face_q        <= 3'd0;
         face_player_q <= '0;
         done_q        <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         last_q        <= last_d;
         winner_q      <= winner_d;
         dice_en_q     <= dice_en_d;
         grant_q       <= grant_d;
         face_q        <= face_d;
         face_player_q <= face_player_d;
         done_q        <= done_d;
         busy_q        <= busy_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      winner_d = winner_q;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               state_d  = StRoll;
               cnt_d    = CW'(ROLL_CYCLES);
               winner_d = pick;
            end
         end
         StRoll: begin
            if (cnt_q == CW'(1)) begin
               state_d = StSettle;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         StSettle: begin
            if (face_ok) begin
               state_d = StShow;
               cnt_d   = CW'(SHOW_CYCLES);
               last_d  = winner_q;
            end
         end
         StShow: begin
            if (cnt_q == CW'(1)) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are registered: compute their next values from the next state.
   always_comb begin
      busy_d  = (state_d != StIdle);
      done_d  = (state_q == StSettle) && face_ok;
      // An invalid sample in SETTLE advances the generator for one more cycle.
      dice_en_d = (state_d == StRoll) || ((state_q == StSettle) && !face_ok);
      grant_d = '0;
      if (state_d != StIdle) begin
         grant_d[winner_d] = 1'b1;
      end
      face_d        = done_d ? dice_val : face_q;
      face_player_d = done_d ? winner_q : face_player_q;
   end

   assign dice_en     = dice_en_q;
   assign grant       = grant_q;
   assign face        = face_q;
   assign face_player = face_player_q;
   assign done        = done_q;
   assign busy        = busy_q;

`ifdef DICE_SCORE_EN
   logic [NUM_PLAYERS*8-1:0] score_q, score_d;
   logic [8:0]               score_sum;

   always_comb begin
      score_d   = score_q;
      score_sum = {1'b0, score_q[{winner_q, 3'b000} +: 8]} + {6'b0, dice_val};
      if (done_d) begin
         score_d[{winner_q, 3'b000} +: 8] = score_sum[8] ? 8'hFF : score_sum[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         score_q <= '0;
      end else begin
         score_q <= score_d;
      end
   end

   assign score = score_q;
`endif

endmodule

// File: tb/tb_dice_roll_sched.sv
// Randomized bench for dice_roll_sched checked every cycle against an age-based roll model,
// with directed scenarios pinning latencies and ordering. Honours DICE_SCORE_EN.
`timescale 1ns/1ps
module tb_dice_roll_sched;

   localparam int NP   = 4;
   localparam int ROLL = 16;
   localparam int SHOW = 32;

   logic          clk;
   logic          rst;
   logic [NP-1:0] req;
   logic [2:0]    dice_val;
   logic          dice_en;
   logic [NP-1:0] grant;
   logic [2:0]    face;
   logic [1:0]    face_player;
   logic          done;
   logic          busy;
`ifdef DICE_SCORE_EN
   logic [NP*8-1:0] score;
`endif

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   dice_roll_sched #(
      .NUM_PLAYERS (NP),
      .ROLL_CYCLES (ROLL),
      .SHOW_CYCLES (SHOW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .dice_val    (dice_val),
      .dice_en     (dice_en),
      .grant       (grant),
      .face        (face),
      .face_player (face_player),
      .done        (done),
`ifdef DICE_SCORE_EN
      .score       (score),
`endif
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: m_age counts cycles since the grant edge; rolling for ages 0..ROLL-1, then
   // sampling until a valid face, then showing SHOW cycles from the done cycle.
   bit m_init = 1'b0;
   bit m_active;
   int m_win, m_last, m_age, m_done_age, m_face, m_fp;
   int m_score [NP];

   always @(posedge clk) begin
      if (rst) begin
         m_init     = 1'b1;
         m_active   = 1'b0;
         m_last     = NP - 1;
         m_win      = 0;
         m_age      = 0;
         m_done_age = -1;
         m_face     = 0;
         m_fp       = 0;
         for (int p = 0; p < NP; p++) m_score[p] = 0;
      end else if (m_init) begin
         if (!m_active) begin
            if (req != '0) begin
               bit found;
               found = 1'b0;
               for (int i = 1; i <= NP; i++) begin
                  if (!found && req[(m_last + i) % NP]) begin
                     found = 1'b1;
                     m_win = (m_last + i) % NP;
                  end
               end
               m_active   = 1'b1;
               m_age      = 0;
               m_done_age = -1;
            end
         end else begin
            if (m_done_age < 0 && m_age >= ROLL) begin
               if (dice_val >= 3'd1 && dice_val <= 3'd6) begin
                  m_face     = int'(dice_val);
                  m_fp       = m_win;
                  m_last     = m_win;
                  m_done_age = m_age + 1;
                  m_score[m_win] = m_score[m_win] + int'(dice_val);
                  if (m_score[m_win] > 255) m_score[m_win] = 255;
               end
            end else if (m_done_age >= 0 && m_age == m_done_age + SHOW - 1) begin
               m_active = 1'b0;
            end
            m_age++;
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("busy", int'(busy), int'(m_active));
         chk("grant", int'(grant), m_active ? (1 << m_win) : 0);
         chk("dice_en", int'(dice_en),
             int'(m_active && (m_age < ROLL || (m_done_age < 0 && m_age > ROLL))));
         chk("done", int'(done), int'(m_active && m_age == m_done_age));
         chk("face", int'(face), m_face);
         chk("face_player", int'(face_player), m_fp);
`ifdef DICE_SCORE_EN
         for (int p = 0; p < NP; p++) chk("score", int'(score[p*8 +: 8]), m_score[p]);
`endif
      end
   end

   // Watch one roll from the current idle cycle until the DUT is idle again after done.
   task automatic observe(input int limit, input logic [2:0] s0, input logic [2:0] s1,
                          input logic [2:0] s2, input int drop_at,
                          output int tg, output int td, output int tda, output int ne,
                          output int ti, output int gv, output int fc, output int fp,
                          output int nd);
      int idx;
      tg = -1; td = -1; tda = -1; ne = 0; ti = -1; gv = 0; fc = -1; fp = -1; nd = 0;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk);
         if (grant != '0 && tg < 0) begin
            tg = k;
            gv = int'(grant);
         end
         if (dice_en) ne++;
         if (done) begin
            nd++;
            td  = k;
            tda = cyc;
            fc  = int'(face);
            fp  = int'(face_player);
         end
         if (td >= 0 && !busy) begin
            ti = k;
            break;
         end
         if (tg >= 0) begin
            if (k == tg + drop_at) req = '0;
            idx = k - tg - ROLL;
            if (idx < 0) dice_val = 3'($urandom_range(0, 7));
            else dice_val = (idx == 0) ? s0 : (idx == 1) ? s1 : s2;
         end
      end
   endtask

   int tg, td, tda, ne, ti, gv, fc, fp, nd, prev;

   initial begin
      rst = 1'b1;
      req = '0;
      dice_val = 3'd3;
      repeat (3) @(negedge clk);
      chk("rst_grant", int'(grant), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_dice_en", int'(dice_en), 0);
      chk("rst_face", int'(face), 0);
      chk("rst_face_player", int'(face_player), 0);
      chk("rst_done", int'(done), 0);

      // Single request from player 2 with a constant valid face.
      rst = 1'b0;
      req = 4'b0100;
      observe(200, 3'd3, 3'd3, 3'd3, -1, tg, td, tda, ne, ti, gv, fc, fp, nd);
      chk("s1_grant_latency", tg, 0);
      chk("s1_grant", gv, 4);
      chk("s1_en_cycles", ne, 16);
      chk("s1_done_latency", td, 17);
      chk("s1_face", fc, 3);
      chk("s1_player", fp, 2);
      chk("s1_show_len", ti - td, 32);
      chk("s1_done_count", nd, 1);

      // All players requesting: rotation 0,1,2,3,0 at 50-cycle spacing.
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      req = 4'b1111;
      prev = 0;
      for (int r = 0; r < 5; r++) begin
         observe(200, 3'd4, 3'd4, 3'd4, -1, tg, td, tda, ne, ti, gv, fc, fp, nd);
         chk("s2_player", fp, r % 4);
         if (r > 0) chk("s2_spacing", tda - prev, 50);
         prev = tda;
      end

      // Invalid samples 7 then 0 before a valid 5.
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      req = 4'b0001;
      observe(200, 3'd7, 3'd0, 3'd5, -1, tg, td, tda, ne, ti, gv, fc, fp, nd);
      chk("s3_en_cycles", ne, 18);
      chk("s3_done_count", nd, 1);
      chk("s3_face", fc, 5);
      chk("s3_done_latency", td, 19);

      // Reset in cycle 8 of ROLL, then player 0 must win against player 2.
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      req = 4'b0100;
      for (int k = 0; k < 10 && grant == '0; k++) @(negedge clk);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      chk("s4_grant", int'(grant), 0);
      chk("s4_dice_en", int'(dice_en), 0);
      chk("s4_face", int'(face), 0);
      chk("s4_done", int'(done), 0);
      rst = 1'b0;
      req = 4'b0101;
      observe(200, 3'd2, 3'd2, 3'd2, -1, tg, td, tda, ne, ti, gv, fc, fp, nd);
      chk("s4_next_grant", gv, 1);
      chk("s4_next_player", fp, 0);

      // Granted request drops mid-roll; the roll still completes for player 1.
      req = 4'b0010;
      observe(200, 3'd6, 3'd6, 3'd6, 3, tg, td, tda, ne, ti, gv, fc, fp, nd);
      chk("s5_done_count", nd, 1);
      chk("s5_player", fp, 1);
      chk("s5_face", fc, 6);

`ifdef DICE_SCORE_EN
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      req = 4'b0010;
      for (int r = 0; r < 52; r++) begin
         observe(200, 3'd5, 3'd5, 3'd5, -1, tg, td, tda, ne, ti, gv, fc, fp, nd);
      end
      chk("s6_score_p1", int'(score[15:8]), 255);
      chk("s6_score_others", int'(score & ~32'h0000_FF00), 0);
`endif

      // Random traffic, generator values and occasional resets.
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
         dice_val = 3'($urandom_range(0, 7));
      end
      rst = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
